// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

   // Bit-index counter width; a width of at least one bit keeps the counter legal.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/full_sub_bit.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: in_data1 - in_data2, one bit per clock, LSB first,
// with a start/busy/done handshake and a borrow-out flag.
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out_data,
   output logic             bw
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state;
   state_t           next_state;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sr;
   logic [CNT_W-1:0] cnt;
   logic             brw;
   logic             last_bit;

   logic             bit_a;
   logic             bit_b;
   logic             bit_d;
   logic             bit_bout;

   logic             accept;
   logic             step;
   logic             finish;

   assign bit_a = a[cnt];
   assign bit_b = b[cnt];

   full_sub_bit u_cell (
      .a    (bit_a),
      .b    (bit_b),
      .bin  (brw),
      .d    (bit_d),
      .bout (bit_bout)
   );

   // Busy covers both the bit-processing phase and the result-presentation cycle.
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Next-state decode; RUN holds one extra cycle after the last bit so the
   // result register is loaded exactly on DONE entry.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
               accept     = 1'b1;
            end
         end
         RUN: begin
            if (last_bit) begin
               next_state = DONE;
               finish     = 1'b1;
            end else begin
               step = 1'b1;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Operand capture, per-bit subtraction and right-shifting result assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a        <= '0;
         b        <= '0;
         sr       <= '0;
         cnt      <= '0;
         brw      <= 1'b0;
         last_bit <= 1'b0;
      end else if (accept) begin
         a        <= in_data1;
         b        <= in_data2;
         sr       <= '0;
         cnt      <= '0;
         brw      <= 1'b0;
         last_bit <= 1'b0;
      end else if (step) begin
         sr       <= {bit_d, sr[WIDTH-1:1]};
         brw      <= bit_bout;
         cnt      <= cnt + 1'b1;
         last_bit <= (cnt == CNT_W'(WIDTH - 1));
      end
   end

   // Result registers only change when a finished difference is published.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         bw       <= 1'b0;
      end else if (finish) begin
         out_data <= sr;
         bw       <= brw;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             start    = 1'b0;
   logic [WIDTH-1:0] in_data1 = '0;
   logic [WIDTH-1:0] in_data2 = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out_data;
   logic             bw;

   int checks     = 0;
   int failures   = 0;
   bit compare_en = 1'b0;

   // Behavioural model: an accepted operation stays busy for WIDTH+2 cycles,
   // and its difference appears WIDTH+1 cycles after acceptance.
   logic [WIDTH-1:0] m_a   = '0;
   logic [WIDTH-1:0] m_b   = '0;
   logic [WIDTH-1:0] m_out = '0;
   bit               m_bw  = 1'b0;
   bit               m_busy = 1'b0;
   int               m_age  = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .in_data1 (in_data1),
      .in_data2 (in_data2),
      .busy     (busy),
      .done     (done),
      .out_data (out_data),
      .bw       (bw)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model update on every clock, cleared asynchronously by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_age  = 0;
         m_out  = '0;
         m_bw   = 1'b0;
      end else if (!m_busy) begin
         if (start) begin
            m_a    = in_data1;
            m_b    = in_data2;
            m_busy = 1'b1;
            m_age  = 0;
         end
      end else begin
         m_age++;
         if (m_age == WIDTH + 1) begin
            m_out = m_a - m_b;
            m_bw  = (m_a < m_b);
         end else if (m_age == WIDTH + 2) begin
            m_busy = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (compare_en) begin
         check_output("model_busy", 32'(busy), 32'(m_busy));
         check_output("model_done", 32'(done), 32'(m_busy && (m_age == WIDTH + 1)));
         check_output("model_out_data", 32'(out_data), 32'(m_out));
         check_output("model_bw", 32'(bw), 32'(m_bw));
      end
   end

   // Wait for the done pulse, counting falling edges since the accepting edge.
   task automatic wait_done(input bit scramble, output int lat, output bit seen);
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         if (done === 1'b1) begin
            seen = 1'b1;
         end else if (scramble) begin
            in_data1 = 4'($urandom_range(15));
            in_data2 = 4'($urandom_range(15));
         end
      end
   endtask

   // Run one operation from IDLE and check latency, result and pulse shape.
   task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] exp_out, input logic exp_bw,
                                 input string tag);
      int lat;
      bit seen;
      @(posedge clk);
      #1;
      start    = 1'b1;
      in_data1 = a;
      in_data2 = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0, lat, seen);
      if (!seen) begin
         check_output({tag, "_done_timeout"}, 32'(seen), 32'd1);
      end else begin
         check_output({tag, "_latency"}, 32'(lat - 1), 32'd5);
         check_output({tag, "_out_data"}, 32'(out_data), 32'(exp_out));
         check_output({tag, "_bw"}, 32'(bw), 32'(exp_bw));
         @(negedge clk);
         check_output({tag, "_done_width"}, 32'(done), 32'd0);
         check_output({tag, "_busy_drop"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int  lat;
      bit  seen;
      bit  any_done;

      // Reset state
      repeat (2) @(negedge clk);
      compare_en = 1'b1;
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      check_output("reset_out_data", 32'(out_data), 32'd0);
      check_output("reset_bw", 32'(bw), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed vectors with hand-computed results
      apply_stimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, "d_1m1");
      apply_stimulus(4'b0001, 4'b0011, 4'b1110, 1'b1, "d_1m3");
      apply_stimulus(4'b1111, 4'b0001, 4'b1110, 1'b0, "d_15m1");
      apply_stimulus(4'b0000, 4'b0001, 4'b1111, 1'b1, "d_0m1");

      // Start held high, operands scrambled during RUN
      @(posedge clk);
      #1;
      start    = 1'b1;
      in_data1 = 4'b1010;
      in_data2 = 4'b0011;
      @(posedge clk);
      #1;
      wait_done(1'b1, lat, seen);
      check_output("held_first_seen", 32'(seen), 32'd1);
      check_output("held_first_out", 32'(out_data), 32'b0111);
      check_output("held_first_bw", 32'(bw), 32'd0);
      @(posedge clk);
      #1;
      in_data1 = 4'b0101;
      in_data2 = 4'b0110;
      @(negedge clk);
      check_output("held_idle_gap", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_output("held_restart_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      wait_done(1'b1, lat, seen);
      check_output("held_second_seen", 32'(seen), 32'd1);
      check_output("held_second_out", 32'(out_data), 32'b1111);
      check_output("held_second_bw", 32'(bw), 32'd1);
      @(negedge clk);

      // Reset in the second RUN cycle aborts without a done pulse
      @(posedge clk);
      #1;
      start    = 1'b1;
      in_data1 = 4'b1110;
      in_data2 = 4'b0001;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_done", 32'(done), 32'd0);
      check_output("abort_out_data", 32'(out_data), 32'd0);
      check_output("abort_bw", 32'(bw), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      any_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done !== 1'b0) any_done = 1'b1;
      end
      check_output("abort_no_done", 32'(any_done), 32'd0);
      apply_stimulus(4'b0011, 4'b0001, 4'b0010, 1'b0, "post_abort");

      // Exhaustive operand pairs against plain arithmetic
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            apply_stimulus(4'(a), 4'(b), 4'((a - b) & 15), (a < b),
                           $sformatf("exh_%0d_%0d", a, b));
         end
      end

      compare_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the inverse counterpart of the 4-bit parallel adder. It computes in_data1 - in_data2 one bit per clock, LSB first, under a start/busy/done handshake, and produces the difference plus a borrow-out. It is used where a single full-subtractor cell is traded for WIDTH cycles of latency. Results can be cross-checked against the adder: out_data + in_data2 == in_data1 mod 2^WIDTH.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
in_data1  input  WIDTH  minuend, captured when start is accepted
in_data2  input  WIDTH  subtrahend, captured when start is accepted
busy  output  1  high while an operation is in progress (RUN and DONE)
done  output  1  one-cycle pulse; out_data and bw valid in this cycle
out_data  output  WIDTH  difference in_data1 - in_data2 mod 2^WIDTH, held until next completion
bw  output  1  borrow-out: 1 iff in_data1 < in_data2 (unsigned), held with out_data

Behaviour:
- Interface as decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, busy=0, done=0, out_data=0, bw=0. Internal operand registers, shift register, bit counter and borrow flop are cleared.
- States:
  - IDLE -> RUN on start=1.
  - RUN -> DONE after the WIDTH-th bit is processed.
  - DONE -> IDLE unconditionally after 1 cycle.
- Accept (IDLE and start=1):
  - latch a<=in_data1, b<=in_data2
  - cnt<=0, brw<=0, busy<=1
- RUN, one bit per cycle, with i=cnt:
  - d = a[i] ^ b[i] ^ brw
  - brw' = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw)
  - d shifts into the MSB of the shift register (right-shift), so after WIDTH bits bit i lands in position i
  - cnt increments; when cnt == WIDTH-1 the state goes to DONE
- DONE entry (registered): out_data <= final shift-register value, bw <= final brw. done=1 for exactly one cycle; busy stays 1 during DONE.
- Latency: start is sampled at edge N and done is high in the cycle following edge N+WIDTH+1. With WIDTH=4 that is 5 cycles after acceptance. Minimum start-to-start interval is WIDTH+2 cycles.
- start while busy=1 is ignored: operands are not re-latched and no queueing occurs.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Input changes during RUN have no effect, because operands are latched.
- Asserting rst_n low mid-operation aborts immediately: outputs go to reset values and no done pulse is produced.
- out_data and bw change only on DONE entry or reset. Between operations they hold the last result.
- Wrap-around: the result is modulo 2^WIDTH and bw flags the underflow. in_data1 == in_data2 gives 0 with bw=0.

Decomposition:
- Package sub_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH localparam
  - counter width expression clog2(WIDTH)
- One natural sub-module: full_sub_bit (combinational 1-bit full subtractor: a, b, bin -> d, bout), instantiated once in the datapath.
- The FSM, counter and shift register stay in serial_subtractor.

Test Plan:
- After reset: busy=0, done=0, out_data=0000, bw=0. 0001-0001 -> done pulse exactly 5 cycles after start accepted; out_data=0000, bw=0.
- 0001-0011 -> out_data=1110, bw=1. 1111-0001 -> out_data=1110, bw=0. 0000-0001 -> out_data=1111, bw=1.
- Start held high with in_data changing every cycle during RUN -> the result matches the operands latched at acceptance. The second operation begins the cycle after DONE.
- Reset pulse in the 2nd RUN cycle of 1110-0001 -> immediate reset values, no done pulse; the next op 0011-0001 gives 0010, bw=0.
- Exhaustive 256 pairs (WIDTH=4) compared against a reference model: out_data == (a-b)&4'hF and bw == (a<b). Check that done is exactly one cycle wide and that busy deasserts one cycle after done.
